ifu_itcm_fetch_rsp: RTL and testbench
=====================================

// Module: ifu_itcm_fetch_rsp
// PURPOSE
//  Responder end of the IFU instruction-fetch channel (ifu_req_* / ifu_rsp_*).
//  Accepts fetch requests, reads a word-wide synchronous ITCM SRAM and returns instruction or error responses in order.
//  Holds up to OUTS_DEPTH responses under ifu_rsp_ready backpressure. Sits between the IFU fetch stage and the ITCM macro.
// PARAMETERS
//  PC_SIZE     32            fetch address width
//  INSTR_SIZE  32            instruction / SRAM data width
//  ITCM_AW     16            byte-address width of the ITCM window (64 KiB)
//  ITCM_BASE   32'h8000_0000 window base; low ITCM_AW bits are zero
//  OUTS_DEPTH  2             max requests accepted but not yet returned (>=2)
// PORTS
//  clk              in   1            core clock
//  rst_n            in   1            asynchronous active-low reset
//  ifu_req_valid    in   1            fetch request valid
//  ifu_req_ready    out  1            fetch request ready
//  ifu_req_pc       in   PC_SIZE      fetch byte address
//  ifu_rsp_valid    out  1            response valid
//  ifu_rsp_ready    in   1            response ready
//  ifu_rsp_err      out  1            response is a bus error (instr forced to 0)
//  ifu_rsp_instr    out  INSTR_SIZE   fetched instruction
//  ram_cs           out  1            SRAM read strobe
//  ram_addr         out  ITCM_AW-2    SRAM word address = ifu_req_pc[ITCM_AW-1:2]
//  ram_dout         in   INSTR_SIZE   SRAM read data, valid the cycle after ram_cs, held until next read
//  busy             out  1            any request accepted and not yet returned
// BEHAVIOUR
//  - Reset: rd_pending=0, response FIFO empty; ifu_rsp_valid=0, ifu_rsp_err=0, ifu_rsp_instr=0, ram_cs=0, busy=0, ifu_req_ready=1.
//  - Handshakes: req/rsp transfer when valid&ready at clk rising edge. valid must not depend on ready.
//  - ifu_req_ready = (fifo_cnt + rd_pending) < OUTS_DEPTH. Registered state only, no path from ifu_rsp_ready.
//  - Decode on req handshake, cycle N:
//    - in_win = pc[PC_SIZE-1:ITCM_AW] == ITCM_BASE[PC_SIZE-1:ITCM_AW]
//    - mis = |pc[1:0]
//    - err = ~in_win | mis
//  - ram_cs = req handshake & ~err (combinational). An error request issues no SRAM read.
//  - Cycle N+1: rd_pending=1, rd_err=err. Slot data = err ? 0 : ram_dout.
//  - Response selection (1-cycle latency):
//    - ifu_rsp_valid = fifo_nonempty | rd_pending
//    - Data/err come from the FIFO head when it is nonempty, otherwise from the pending slot (bypass).
//  - Pending slot resolution, each cycle rd_pending=1:
//    - If bypass is selected and ifu_rsp_ready=1, the slot is consumed directly.
//    - Otherwise {rd_err, data} is pushed into the FIFO that cycle. ram_dout is never sampled later than N+1.
//  - Simultaneous FIFO push and pop in one cycle is legal. fifo_cnt stays unchanged.
//  - Overflow cannot occur, because the ready rule reserves space. Underflow: pop only when ifu_rsp_valid.
//  - Ordering: responses are strictly in request order, errors included.
//  - Throughput: 1 request/cycle is sustained while ifu_rsp_ready=1.
//  - Stall: with ifu_rsp_ready=0, at most OUTS_DEPTH requests are accepted, then ifu_req_ready=0.
//  - Widths: FIFO entry = 1+INSTR_SIZE. fifo_cnt and pointers use clog2(OUTS_DEPTH)+1 / clog2(OUTS_DEPTH) bits; pointers wrap modulo OUTS_DEPTH.
//  - busy = rd_pending | fifo_nonempty.
//  - Reset mid-operation: all state clears asynchronously. In-flight responses are discarded and no response is emitted after reset release.
// TESTING
//  1. Reset, pc=32'h8000_0000, ITCM word0=32'h0000_0013, rsp_ready=1
//     -> ram_cs=1 and ram_addr=0 in N; rsp_valid=1, instr=32'h13, err=0 in N+1.
//  2. Back-to-back pcs 0x8000_0000/4/8/C, rsp_ready=1
//     -> req_ready stays 1; 4 responses on consecutive cycles, in order.
//  3. rsp_ready=0, 3 requests offered
//     -> first 2 accepted, req_ready=0 with busy=1; raise rsp_ready -> 2 in-order responses, then the third is accepted.
//  4. pc=32'h8001_0000 (out of window), then pc=32'h8000_0002 (misaligned)
//     -> ram_cs=0 for both; rsp err=1, instr=0 for each, in order.
//  5. Error request between two good ones, rsp_ready toggling 1/0 each cycle
//     -> order good/err/good preserved; no data corruption from ram_dout reuse.
//  6. Assert rst_n=0 with 2 responses held
//     -> rsp_valid=0, busy=0, req_ready=1 immediately; no stale response after release.

Source files
------------

// File: rtl/ifu_itcm_fetch_rsp.sv
// ifu_itcm_fetch_rsp: IFU fetch responder in front of a synchronous ITCM SRAM.
// Ports: clk/rst_n; ifu_req_* fetch request; ifu_rsp_* in-order response;
//        ram_cs/ram_addr/ram_dout SRAM read port; busy = work in flight.
module ifu_itcm_fetch_rsp #(
    parameter int                  PC_SIZE    = 32,
    parameter int                  INSTR_SIZE = 32,
    parameter int                  ITCM_AW    = 16,
    parameter logic [PC_SIZE-1:0]  ITCM_BASE  = 32'h8000_0000,
    parameter int                  OUTS_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req_valid,
    output logic                  ifu_req_ready,
    input  logic [PC_SIZE-1:0]    ifu_req_pc,
    output logic                  ifu_rsp_valid,
    input  logic                  ifu_rsp_ready,
    output logic                  ifu_rsp_err,
    output logic [INSTR_SIZE-1:0] ifu_rsp_instr,
    output logic                  ram_cs,
    output logic [ITCM_AW-3:0]    ram_addr,
    input  logic [INSTR_SIZE-1:0] ram_dout,
    output logic                  busy
);

    localparam int CW = $clog2(OUTS_DEPTH) + 1;
    localparam int PW = $clog2(OUTS_DEPTH);
    localparam int EW = INSTR_SIZE + 1;

    logic [EW-1:0] r_mem [OUTS_DEPTH];
    logic [CW-1:0] r_cnt;
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic          r_rd_pending;
    logic          r_rd_err;

    logic          w_req_hs;
    logic          w_in_win;
    logic          w_mis;
    logic          w_err;
    logic          w_fifo_ne;
    logic [EW-1:0] w_slot;
    logic [EW-1:0] w_head;
    logic          w_pop;
    logic          w_bypass;
    logic          w_push;
    logic [CW:0]   w_occ;

    // Ready only looks at registered occupancy so it never depends on rsp_ready.
    assign w_occ = {1'b0, r_cnt} + {{CW{1'b0}}, r_rd_pending};
    assign ifu_req_ready = (w_occ < (CW+1)'(OUTS_DEPTH));

    assign w_req_hs = ifu_req_valid & ifu_req_ready;
    assign w_in_win = (ifu_req_pc[PC_SIZE-1:ITCM_AW] ==
                       ITCM_BASE[PC_SIZE-1:ITCM_AW]);
    assign w_mis    = |ifu_req_pc[1:0];
    assign w_err    = ~w_in_win | w_mis;

    assign ram_cs   = w_req_hs & ~w_err;
    assign ram_addr = ifu_req_pc[ITCM_AW-1:2];

    assign w_fifo_ne = (r_cnt != '0);
    assign w_slot    = r_rd_err ? {1'b1, {INSTR_SIZE{1'b0}}}
                                : {1'b0, ram_dout};
    assign w_head    = r_mem[r_rptr];

    assign ifu_rsp_valid = w_fifo_ne | r_rd_pending;

    always_comb begin
        ifu_rsp_err   = 1'b0;
        ifu_rsp_instr = '0;
        if (w_fifo_ne) begin
            ifu_rsp_err   = w_head[INSTR_SIZE];
            ifu_rsp_instr = w_head[INSTR_SIZE-1:0];
        end else if (r_rd_pending) begin
            ifu_rsp_err   = w_slot[INSTR_SIZE];
            ifu_rsp_instr = w_slot[INSTR_SIZE-1:0];
        end
    end

    // The pending slot either leaves directly (bypass) or is parked in the
    // FIFO right away, so ram_dout is never needed past its first cycle.
    assign w_pop    = w_fifo_ne & ifu_rsp_ready;
    assign w_bypass = r_rd_pending & ~w_fifo_ne & ifu_rsp_ready;
    assign w_push   = r_rd_pending & ~w_bypass;

    assign busy = r_rd_pending | w_fifo_ne;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_pending <= 1'b0;
            r_rd_err     <= 1'b0;
        end else begin
            r_rd_pending <= w_req_hs;
            if (w_req_hs) begin
                r_rd_err <= w_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= (r_wptr == PW'(OUTS_DEPTH-1)) ? '0 : r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == PW'(OUTS_DEPTH-1)) ? '0 : r_rptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_slot;
        end
    end

endmodule

// File: tb/tb_ifu_itcm_fetch_rsp.sv
// tb_ifu_itcm_fetch_rsp: directed scoreboard bench for ifu_itcm_fetch_rsp.
// Drives inputs after negedge, samples 1ns later, models the SRAM contents.
module tb_ifu_itcm_fetch_rsp;

    logic        clk;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic        ifu_rsp_err;
    logic [31:0] ifu_rsp_instr;
    logic        ram_cs;
    logic [13:0] ram_addr;
    logic [31:0] ram_dout;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [32:0] q[$];
    logic        l_req_hs;
    logic        l_rsp_hs;
    logic        tgl;

    ifu_itcm_fetch_rsp dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_pc    (ifu_req_pc),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_err   (ifu_rsp_err),
        .ifu_rsp_instr (ifu_rsp_instr),
        .ram_cs        (ram_cs),
        .ram_addr      (ram_addr),
        .ram_dout      (ram_dout),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [13:0] a);
        if (a == 14'd0) return 32'h0000_0013;
        return 32'hC0DE_0000 | {18'd0, a};
    endfunction

    // SRAM model: data valid the cycle after cs, held until next read
    initial ram_dout = 32'h0;
    always @(posedge clk) begin
        if (ram_cs) ram_dout <= word(ram_addr);
    end

    function automatic logic [32:0] model(input logic [31:0] pc);
        logic e;
        e = (pc[31:16] != 16'h8000) || (pc[1:0] != 2'b00);
        return e ? {1'b1, 32'h0} : {1'b0, word(pc[15:2])};
    endfunction

    task automatic chk(input string tag, input logic [63:0] o,
                       input logic [63:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
        end
    endtask

    task automatic step(input logic v, input logic [31:0] pc,
                        input logic rr);
        logic [32:0] ex;
        ifu_req_valid = v;
        ifu_req_pc    = pc;
        ifu_rsp_ready = rr;
        #1;
        l_req_hs = v & ifu_req_ready;
        l_rsp_hs = ifu_rsp_valid & rr;
        if (l_rsp_hs) begin
            if (q.size() == 0) begin
                chk("unexpected_rsp", 64'd1, 64'd0);
            end else begin
                ex = q.pop_front();
                chk("rsp", {31'd0, ifu_rsp_err, ifu_rsp_instr}, {31'd0, ex});
            end
        end
        if (l_req_hs) begin
            ex = model(pc);
            q.push_back(ex);
            chk("ram_cs", {63'd0, ram_cs}, {63'd0, ~ex[32]});
            if (!ex[32]) chk("ram_addr", {50'd0, ram_addr}, {50'd0, pc[15:2]});
        end
        @(negedge clk);
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (q.size() > 0 && n < max) begin
            step(1'b0, 32'h0, 1'b1);
            n++;
        end
        chk("drain_left", 64'(q.size()), 64'd0);
    endtask

    task automatic offer(input logic [31:0] pc);
        int n = 0;
        l_req_hs = 1'b0;
        while (!l_req_hs && n < 30) begin
            step(1'b1, pc, tgl);
            tgl = ~tgl;
            n++;
        end
        chk("offer_accepted", {63'd0, l_req_hs}, 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        ifu_req_valid = 1'b0;
        ifu_req_pc = 32'h0;
        ifu_rsp_ready = 1'b0;
        tgl = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_rsp_valid", {63'd0, ifu_rsp_valid}, 64'd0);
        chk("rst_rsp_err", {63'd0, ifu_rsp_err}, 64'd0);
        chk("rst_rsp_instr", {32'd0, ifu_rsp_instr}, 64'd0);
        chk("rst_ram_cs", {63'd0, ram_cs}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_req_ready", {63'd0, ifu_req_ready}, 64'd1);
        @(negedge clk);

        // 1: single fetch, 1-cycle latency
        step(1'b1, 32'h8000_0000, 1'b1);
        chk("t1_hs", {63'd0, l_req_hs}, 64'd1);
        step(1'b0, 32'h0, 1'b1);
        chk("t1_rsp_next", {63'd0, l_rsp_hs}, 64'd1);
        chk("t1_q_empty", 64'(q.size()), 64'd0);

        // 2: back-to-back at full rate
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h8000_0000 + 32'(i * 4), 1'b1);
            chk("t2_req_hs", {63'd0, l_req_hs}, 64'd1);
            if (i > 0) chk("t2_rsp_hs", {63'd0, l_rsp_hs}, 64'd1);
        end
        step(1'b0, 32'h0, 1'b1);
        chk("t2_last_rsp", {63'd0, l_rsp_hs}, 64'd1);
        chk("t2_q_empty", 64'(q.size()), 64'd0);

        // 3: stall, only OUTS_DEPTH accepted
        step(1'b1, 32'h8000_0010, 1'b0);
        chk("t3_a", {63'd0, l_req_hs}, 64'd1);
        step(1'b1, 32'h8000_0014, 1'b0);
        chk("t3_b", {63'd0, l_req_hs}, 64'd1);
        step(1'b1, 32'h8000_0018, 1'b0);
        chk("t3_c_blocked", {63'd0, l_req_hs}, 64'd0);
        chk("t3_busy", {63'd0, busy}, 64'd1);
        step(1'b1, 32'h8000_0018, 1'b0);
        chk("t3_still_blocked", {63'd0, ifu_req_ready}, 64'd0);
        step(1'b1, 32'h8000_0018, 1'b1);
        chk("t3_c_wait", {63'd0, l_req_hs}, 64'd0);
        chk("t3_pop_a", {63'd0, l_rsp_hs}, 64'd1);
        step(1'b1, 32'h8000_0018, 1'b1);
        chk("t3_c_acc", {63'd0, l_req_hs}, 64'd1);
        drain(10);

        // 4: out-of-window then misaligned
        step(1'b1, 32'h8001_0000, 1'b1);
        chk("t4_oow_hs", {63'd0, l_req_hs}, 64'd1);
        step(1'b1, 32'h8000_0002, 1'b1);
        chk("t4_mis_hs", {63'd0, l_req_hs}, 64'd1);
        drain(10);

        // 5: good/err/good with rsp_ready toggling
        offer(32'h8000_0020);
        offer(32'h7FFF_FFFC);
        offer(32'h8000_0024);
        offer(32'h8000_0028);
        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            step(1'b0, 32'h0, tgl);
            tgl = ~tgl;
        end
        chk("t5_q_empty", 64'(q.size()), 64'd0);

        // 6: reset with responses held
        step(1'b1, 32'h8000_0030, 1'b0);
        step(1'b1, 32'h8000_0034, 1'b0);
        step(1'b0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rsp_valid", {63'd0, ifu_rsp_valid}, 64'd0);
        chk("t6_busy", {63'd0, busy}, 64'd0);
        chk("t6_req_ready", {63'd0, ifu_req_ready}, 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 32'h0, 1'b1);
            chk("t6_no_stale", {63'd0, ifu_rsp_valid}, 64'd0);
        end
        step(1'b1, 32'h8000_0004, 1'b1);
        drain(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
